branch_resolve_redirect: RTL

- Downstream consumer of the global-history direction predictor.
- Takes the D-stage prediction and branch target and carries them down the D→E→M pipeline. Registers the E-stage actual outcome and detects mispredicts in M.
- Generates fetch redirects and branch flushes.
- Drives branchM, pred_takeM and actual_takeM back to the predictor, and keeps branch and mispredict performance counters.

---
 rtl/branch_resolve_redirect_if.sv | 57 +++++
 rtl/branch_resolve_redirect.sv | 138 +++++++++++++
 2 files changed

// File: rtl/branch_resolve_redirect_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_redirect_if
// Description : Bundle of pipeline-control, branch-info and redirect/flush
//               signals exchanged between the pipeline and the branch
//               resolve/redirect unit. The master drives stalls and branch
//               info; the slave (resolve unit) returns redirects, flushes,
//               predictor feedback and performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_redirect_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    // pipeline control
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             ext_flushE;
    // branch information from D and E
    logic             branchD;
    logic             pred_takeD;
    logic [PC_W-1:0]  pcD;
    logic [PC_W-1:0]  targetD;
    logic             actual_takeE;
    // redirect and flush controls
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             flushD;
    logic             flushE;
    logic             flushM;
    // predictor feedback
    logic             branchM;
    logic             pred_takeM;
    logic             actual_takeM;
    logic             mispredictM;
    // performance counters
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output stallD, stallE, stallM, ext_flushE,
        output branchD, pred_takeD, pcD, targetD, actual_takeE,
        input  redirect, redirect_pc, flushD, flushE, flushM,
        input  branchM, pred_takeM, actual_takeM, mispredictM,
        input  branch_cnt, mispred_cnt
    );

    modport slave (
        input  stallD, stallE, stallM, ext_flushE,
        input  branchD, pred_takeD, pcD, targetD, actual_takeE,
        output redirect, redirect_pc, flushD, flushE, flushM,
        output branchM, pred_takeM, actual_takeM, mispredictM,
        output branch_cnt, mispred_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_redirect.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_redirect
// Description : Carries D-stage branch predictions down the D->E->M pipeline,
//               captures the E-stage outcome, detects mispredicts in M and
//               produces fetch redirects, pipeline flushes, predictor
//               feedback and saturating branch/mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_redirect #(
    parameter int CNT_W = 32,
    parameter int PC_W  = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    branch_resolve_redirect_if.slave  bus
);

    // D/E pipeline register fields
    logic             r_branchE;
    logic             r_pred_takeE;
    logic [PC_W-1:0]  r_pcE;
    logic [PC_W-1:0]  r_targetE;

    // E/M pipeline register fields
    logic             r_branchM;
    logic             r_pred_takeM;
    logic             r_actual_takeM;
    logic [PC_W-1:0]  r_pcM;
    logic [PC_W-1:0]  r_targetM;

    // performance counters
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    // combinational control
    logic             w_mispredictM;
    logic             w_predredirD;
    logic [PC_W-1:0]  w_correct_pc;
    logic             w_redirect;
    logic [PC_W-1:0]  w_redirect_pc;
    logic             w_flushD;
    logic             w_flushE;
    logic             w_flushM;
    logic             w_resolveM;

    localparam logic [PC_W-1:0]  C_PC_INC  = PC_W'(4);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    // A branch in M only resolves on a cycle where M is allowed to advance.
    assign w_resolveM    = r_branchM & ~bus.stallM;
    assign w_mispredictM = w_resolveM & (r_pred_takeM != r_actual_takeM);
    assign w_predredirD  = bus.pred_takeD & bus.branchD & ~bus.stallD;
    // Fall-through address wraps naturally at the PC width.
    assign w_correct_pc  = r_actual_takeM ? r_targetM : (r_pcM + C_PC_INC);

    // Redirect/flush selection: an M mispredict overrides any D prediction.
    always_comb begin
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        w_flushD      = 1'b0;
        w_flushE      = 1'b0;
        w_flushM      = 1'b0;
        if (w_mispredictM) begin
            w_redirect    = 1'b1;
            w_redirect_pc = w_correct_pc;
            w_flushD      = 1'b1;
            w_flushE      = 1'b1;
            w_flushM      = 1'b1;
        end else if (w_predredirD) begin
            w_redirect    = 1'b1;
            w_redirect_pc = bus.targetD;
            w_flushD      = 1'b1;
        end
    end

    // D/E register: clear beats load beats hold; ext bubble also beats stall.
    always_ff @(posedge clk) begin
        if (rst || w_flushE || bus.ext_flushE) begin
            r_branchE    <= 1'b0;
            r_pred_takeE <= 1'b0;
            r_pcE        <= '0;
            r_targetE    <= '0;
        end else if (!bus.stallE) begin
            r_branchE    <= bus.branchD;
            r_pred_takeE <= bus.pred_takeD & bus.branchD;
            r_pcE        <= bus.pcD;
            r_targetE    <= bus.targetD;
        end
    end

    // E/M register: outcome is only meaningful when the E entry is a branch.
    always_ff @(posedge clk) begin
        if (rst || w_flushM) begin
            r_branchM      <= 1'b0;
            r_pred_takeM   <= 1'b0;
            r_actual_takeM <= 1'b0;
            r_pcM          <= '0;
            r_targetM      <= '0;
        end else if (!bus.stallM) begin
            r_branchM      <= r_branchE;
            r_pred_takeM   <= r_pred_takeE;
            r_actual_takeM <= r_branchE & bus.actual_takeE;
            r_pcM          <= r_pcE;
            r_targetM      <= r_targetE;
        end
    end

    // Saturating counters of resolved branches and resolved mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_resolveM) begin
            if (r_branch_cnt != C_CNT_MAX) begin
                r_branch_cnt <= r_branch_cnt + C_CNT_ONE;
            end
            if (w_mispredictM && (r_mispred_cnt != C_CNT_MAX)) begin
                r_mispred_cnt <= r_mispred_cnt + C_CNT_ONE;
            end
        end
    end

    assign bus.redirect     = w_redirect;
    assign bus.redirect_pc  = w_redirect_pc;
    assign bus.flushD       = w_flushD;
    assign bus.flushE       = w_flushE;
    assign bus.flushM       = w_flushM;
    assign bus.branchM      = r_branchM;
    assign bus.pred_takeM   = r_pred_takeM;
    assign bus.actual_takeM = r_actual_takeM;
    assign bus.mispredictM  = w_mispredictM;
    assign bus.branch_cnt   = r_branch_cnt;
    assign bus.mispred_cnt  = r_mispred_cnt;

endmodule
`default_nettype wire
